// File: rtl/icache_refill_unit.sv
// Instruction-cache miss refill engine: issues one load per word of the missing block,
// gathers responses in any order, then writes the block to the icache in offset order.
module icache_refill_unit #(
    parameter int icache_tag_width_p           = 12,
    parameter int icache_entries_p             = 1024,
    parameter int icache_block_size_in_words_p = 4,
    localparam int pc_width_lp                 = icache_tag_width_p + $clog2(icache_entries_p),
    localparam int block_offset_width_lp       = (icache_block_size_in_words_p > 1) ? $clog2(icache_block_size_in_words_p) : 1,
    localparam int count_width_lp              = $clog2(icache_block_size_in_words_p + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             miss_v_i,
    input  logic [pc_width_lp-1:0]           miss_pc_i,
    output logic                             miss_ready_o,
    output logic                             req_v_o,
    output logic [pc_width_lp-1:0]           req_addr_o,
    input  logic                             req_ready_i,
    input  logic                             resp_v_i,
    input  logic [block_offset_width_lp-1:0] resp_offset_i,
    input  logic [31:0]                      resp_data_i,
    output logic                             icache_v_o,
    output logic [pc_width_lp-1:0]           icache_w_pc_o,
    output logic [31:0]                      icache_w_instr_o,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             resp_err_o
);
    localparam int B = icache_block_size_in_words_p;

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] REQ   = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    // Masks select only block-offset bits; for B=1 they are empty, so nothing is cleared or added.
    localparam logic [pc_width_lp-1:0]           off_mask_lp  = pc_width_lp'(B - 1);
    localparam logic [block_offset_width_lp-1:0] idx_mask_lp  = block_offset_width_lp'(B - 1);
    localparam logic [count_width_lp-1:0]        last_cnt_lp  = count_width_lp'(B - 1);

    logic [2:0]                state_q, state_d;
    logic [pc_width_lp-1:0]    base_q, base_d;
    logic [count_width_lp-1:0] req_cnt_q, req_cnt_d;
    logic [count_width_lp-1:0] drain_cnt_q, drain_cnt_d;
    logic [B-1:0]              word_v_q, word_v_d;
    logic [31:0]               buf_q [B];

    logic [block_offset_width_lp-1:0] resp_idx;
    logic [block_offset_width_lp-1:0] drain_idx;
    logic [pc_width_lp-1:0]           drain_addr;
    logic                             capture_window;
    logic                             resp_accept;

    assign resp_idx       = resp_offset_i & idx_mask_lp;
    assign capture_window = (state_q == REQ) || (state_q == WAIT);
    assign resp_accept    = resp_v_i && capture_window && !word_v_q[resp_idx];
    assign drain_addr     = base_q | (pc_width_lp'(drain_cnt_q) & off_mask_lp);
    assign drain_idx      = drain_addr[block_offset_width_lp-1:0] & idx_mask_lp;

    assign miss_ready_o     = (state_q == IDLE);
    assign busy_o           = (state_q != IDLE);
    assign req_v_o          = (state_q == REQ);
    assign req_addr_o       = base_q | (pc_width_lp'(req_cnt_q) & off_mask_lp);
    assign icache_v_o       = (state_q == DRAIN);
    assign icache_w_pc_o    = drain_addr;
    assign icache_w_instr_o = buf_q[drain_idx];
    assign done_o           = (state_q == DONE);
    assign resp_err_o       = resp_v_i && !resp_accept;

    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        req_cnt_d   = req_cnt_q;
        drain_cnt_d = drain_cnt_q;
        word_v_d    = word_v_q;
        if (resp_accept) begin
            word_v_d[resp_idx] = 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (miss_v_i) begin
                    base_d      = miss_pc_i & ~off_mask_lp;
                    word_v_d    = '0;
                    req_cnt_d   = '0;
                    drain_cnt_d = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                if (req_ready_i) begin
                    req_cnt_d = req_cnt_q + count_width_lp'(1);
                    if (req_cnt_q == last_cnt_lp) begin
                        state_d = WAIT;
                    end
                end
            end
            // Completion is judged on registered valid bits, so WAIT always lasts a cycle.
            WAIT: begin
                if (&word_v_q) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                drain_cnt_d = drain_cnt_q + count_width_lp'(1);
                if (drain_cnt_q == last_cnt_lp) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            base_q      <= '0;
            req_cnt_q   <= '0;
            drain_cnt_q <= '0;
            word_v_q    <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            req_cnt_q   <= req_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            word_v_q    <= word_v_d;
        end
    end

    // Data buffer carries no reset; valid bits alone decide what is live.
    always_ff @(posedge clk_i) begin
        if (resp_accept) begin
            buf_q[resp_idx] <= resp_data_i;
        end
    end
endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed bench for icache_refill_unit (B=4, 22-bit word PC): table of refill
// scenarios plus hand-written reset, stray-response and abort sequences.
module tb_icache_refill_unit;
    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        miss_v_i;
    logic [21:0] miss_pc_i;
    logic        miss_ready_o;
    logic        req_v_o;
    logic [21:0] req_addr_o;
    logic        req_ready_i;
    logic        resp_v_i;
    logic [1:0]  resp_offset_i;
    logic [31:0] resp_data_i;
    logic        icache_v_o;
    logic [21:0] icache_w_pc_o;
    logic [31:0] icache_w_instr_o;
    logic        busy_o;
    logic        done_o;
    logic        resp_err_o;

    int checks   = 0;
    int failures = 0;

    icache_refill_unit #(
        .icache_tag_width_p          (12),
        .icache_entries_p            (1024),
        .icache_block_size_in_words_p(4)
    ) dut (
        .clk_i           (clk_i),
        .reset_i         (reset_i),
        .miss_v_i        (miss_v_i),
        .miss_pc_i       (miss_pc_i),
        .miss_ready_o    (miss_ready_o),
        .req_v_o         (req_v_o),
        .req_addr_o      (req_addr_o),
        .req_ready_i     (req_ready_i),
        .resp_v_i        (resp_v_i),
        .resp_offset_i   (resp_offset_i),
        .resp_data_i     (resp_data_i),
        .icache_v_o      (icache_v_o),
        .icache_w_pc_o   (icache_w_pc_o),
        .icache_w_instr_o(icache_w_instr_o),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .resp_err_o      (resp_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [21:0]      pc;
        logic [21:0]      exp_base;
        logic [15:0]      ready_pat;   // bit (cycle-1) mod 16 drives req_ready_i
        int               resp_start;
        int               n_resp;
        logic [4:0][1:0]  off;         // response k uses off[k] / dat[k]
        logic [4:0][31:0] dat;
        logic [3:0][31:0] exp_data;    // expected icache word per offset
        int               exp_done;
        int               exp_err;
        bit               busy_miss;
    } vec_t;

    vec_t vecs [5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle_inputs();
        miss_v_i      = 1'b0;
        miss_pc_i     = '0;
        req_ready_i   = 1'b0;
        resp_v_i      = 1'b0;
        resp_offset_i = '0;
        resp_data_i   = '0;
    endtask

    task automatic run_vec(input vec_t v, input int vi);
        int  req_idx    = 0;
        int  wr_idx     = 0;
        int  first_req  = -1;
        int  first_wr   = -1;
        int  done_cycle = -1;
        int  errs       = 0;
        int  k          = 0;
        bit  done_seen  = 1'b0;
        miss_v_i  = 1'b1;
        miss_pc_i = v.pc;
        step();
        for (int cycle = 1; cycle <= 60 && !done_seen; cycle++) begin
            miss_v_i    = v.busy_miss && (cycle <= 3);
            miss_pc_i   = v.busy_miss ? 22'h2AAAAA : v.pc;
            req_ready_i = v.ready_pat[(cycle - 1) % 16];
            if (cycle >= v.resp_start && k < v.n_resp) begin
                resp_v_i      = 1'b1;
                resp_offset_i = v.off[k];
                resp_data_i   = v.dat[k];
                k++;
            end else begin
                resp_v_i = 1'b0;
            end
            #1;
            chk($sformatf("v%0d_c%0d_busy", vi, cycle), 64'(busy_o), 64'd1);
            chk($sformatf("v%0d_c%0d_miss_ready", vi, cycle), 64'(miss_ready_o), 64'd0);
            if (req_v_o) begin
                if (first_req < 0) first_req = cycle;
                chk($sformatf("v%0d_c%0d_req_addr", vi, cycle), 64'(req_addr_o), 64'(v.exp_base) + 64'(req_idx));
                if (req_ready_i) req_idx++;
            end
            if (icache_v_o) begin
                if (first_wr < 0) first_wr = cycle;
                chk($sformatf("v%0d_c%0d_wr_gapless", vi, cycle), 64'(cycle), 64'(first_wr + wr_idx));
                if (wr_idx < 4) begin
                    chk($sformatf("v%0d_wr%0d_pc", vi, wr_idx), 64'(icache_w_pc_o), 64'(v.exp_base) + 64'(wr_idx));
                    chk($sformatf("v%0d_wr%0d_data", vi, wr_idx), 64'(icache_w_instr_o), 64'(v.exp_data[wr_idx]));
                end
                wr_idx++;
            end
            if (resp_err_o) errs++;
            if (done_o) begin
                done_cycle = cycle;
                done_seen  = 1'b1;
            end
            step();
        end
        idle_inputs();
        #1;
        chk($sformatf("v%0d_after_busy", vi), 64'(busy_o), 64'd0);
        chk($sformatf("v%0d_after_miss_ready", vi), 64'(miss_ready_o), 64'd1);
        chk($sformatf("v%0d_first_req_cycle", vi), 64'(first_req), 64'd1);
        chk($sformatf("v%0d_req_count", vi), 64'(req_idx), 64'd4);
        chk($sformatf("v%0d_wr_count", vi), 64'(wr_idx), 64'd4);
        chk($sformatf("v%0d_done_cycle", vi), 64'(done_cycle), 64'(v.exp_done));
        chk($sformatf("v%0d_err_count", vi), 64'(errs), 64'(v.exp_err));
        $display("vec %0d pc=%06h reqs=%0d writes=%0d done_cycle=%0d errs=%0d", vi, v.pc, req_idx, wr_idx, done_cycle, errs);
        @(negedge clk_i);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int wr_cnt;
        // in order; response for offset 2 lands with the final request acceptance
        vecs[0] = '{22'h001236, 22'h001234, 16'hFFFF, 2, 4,
                    {2'd0, 2'd3, 2'd2, 2'd1, 2'd0},
                    {32'h0, 32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000},
                    {32'hA000_0003, 32'hA000_0002, 32'hA000_0001, 32'hA000_0000}, 11, 0, 1'b0};
        // out-of-order offsets 3,1,0,2
        vecs[1] = '{22'h000ABD, 22'h000ABC, 16'hFFFF, 2, 4,
                    {2'd0, 2'd2, 2'd0, 2'd1, 2'd3},
                    {32'h0, 32'hB000_0002, 32'hB000_0000, 32'hB000_0001, 32'hB000_0003},
                    {32'hB000_0003, 32'hB000_0002, 32'hB000_0001, 32'hB000_0000}, 11, 0, 1'b0};
        // req_ready 1,0,0,1 repeating: accepts at cycles 1,4,5,8, responses 9-12
        vecs[2] = '{22'h002000, 22'h002000, 16'h9999, 9, 4,
                    {2'd0, 2'd3, 2'd2, 2'd1, 2'd0},
                    {32'h0, 32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000},
                    {32'hC000_0003, 32'hC000_0002, 32'hC000_0001, 32'hC000_0000}, 18, 0, 1'b0};
        // duplicate offset 1 with different data: first data must survive
        vecs[3] = '{22'h000041, 22'h000040, 16'hFFFF, 2, 5,
                    {2'd3, 2'd2, 2'd1, 2'd1, 2'd0},
                    {32'hD000_0003, 32'hD000_0002, 32'hEEEE_EEEE, 32'hD000_0001, 32'hD000_0000},
                    {32'hD000_0003, 32'hD000_0002, 32'hD000_0001, 32'hD000_0000}, 12, 1, 1'b0};
        // all-ones PC (no carry out of offset), second miss offered while busy
        vecs[4] = '{22'h3FFFFF, 22'h3FFFFC, 16'hFFFF, 2, 4,
                    {2'd0, 2'd1, 2'd3, 2'd0, 2'd2},
                    {32'h0, 32'hE000_0001, 32'hE000_0003, 32'hE000_0000, 32'hE000_0002},
                    {32'hE000_0003, 32'hE000_0002, 32'hE000_0001, 32'hE000_0000}, 11, 0, 1'b1};

        idle_inputs();
        reset_i = 1'b1;
        @(negedge clk_i);
        @(negedge clk_i);
        #1;
        chk("reset_req_v", 64'(req_v_o), 64'd0);
        chk("reset_icache_v", 64'(icache_v_o), 64'd0);
        chk("reset_busy", 64'(busy_o), 64'd0);
        chk("reset_done", 64'(done_o), 64'd0);
        chk("reset_resp_err", 64'(resp_err_o), 64'd0);
        chk("reset_miss_ready", 64'(miss_ready_o), 64'd1);
        @(negedge clk_i);
        reset_i = 1'b0;
        step();

        // stray response while idle
        resp_v_i      = 1'b1;
        resp_offset_i = 2'd2;
        resp_data_i   = 32'h5555_5555;
        #1;
        chk("stray_idle_err", 64'(resp_err_o), 64'd1);
        chk("stray_idle_busy", 64'(busy_o), 64'd0);
        step();
        resp_v_i = 1'b0;
        #1;
        chk("stray_idle_after_busy", 64'(busy_o), 64'd0);
        chk("stray_idle_after_req_v", 64'(req_v_o), 64'd0);
        chk("stray_idle_after_err", 64'(resp_err_o), 64'd0);
        $display("stray idle response handled");
        @(negedge clk_i);

        // abort with reset in the third DRAIN cycle (after two writes)
        wr_cnt    = 0;
        miss_v_i  = 1'b1;
        miss_pc_i = 22'h000800;
        step();
        miss_v_i    = 1'b0;
        req_ready_i = 1'b1;
        for (int cycle = 1; cycle <= 8; cycle++) begin
            resp_v_i      = (cycle >= 2 && cycle <= 5);
            resp_offset_i = 2'(cycle - 2);
            resp_data_i   = 32'hF000_0000 + 32'(cycle - 2);
            #1;
            if (icache_v_o) wr_cnt++;
            step();
        end
        idle_inputs();
        #1;
        chk("abort_pre_icache_v", 64'(icache_v_o), 64'd1);
        chk("abort_pre_writes", 64'(wr_cnt), 64'd2);
        #1;
        reset_i = 1'b1;
        #1;
        chk("abort_icache_v", 64'(icache_v_o), 64'd0);
        chk("abort_busy", 64'(busy_o), 64'd0);
        chk("abort_req_v", 64'(req_v_o), 64'd0);
        chk("abort_done", 64'(done_o), 64'd0);
        chk("abort_miss_ready", 64'(miss_ready_o), 64'd1);
        @(negedge clk_i);
        reset_i = 1'b0;
        for (int cycle = 0; cycle < 6; cycle++) begin
            #1;
            chk($sformatf("abort_quiet_c%0d_icache_v", cycle), 64'(icache_v_o), 64'd0);
            chk($sformatf("abort_quiet_c%0d_done", cycle), 64'(done_o), 64'd0);
            step();
        end
        $display("reset abort after %0d writes", wr_cnt);

        foreach (vecs[i]) begin
            run_vec(vecs[i], i);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
